// File: rtl/vga_stack_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_stack_display                                                        |
// | 640x480@60 hex text renderer for the stack calculator, 2-stage pipeline, |
// | per-frame input snapshot, colour-bar image mode.                         |
// | Optional build macro: VGA_LEADING_ZERO_BLANK_EN                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_stack_display #(
   parameter int          DIGITS   = 15,
   parameter int          ROWS     = 4,
   parameter int          SCALE    = 1,
   parameter int          ORIGIN_X = 16,
   parameter int          ORIGIN_Y = 16,
   parameter logic [11:0] FG       = 12'hFFF,
   parameter logic [11:0] BG       = 12'h00F
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ROWS*DIGITS*4-1:0]   numbers,
   input  logic                       image,
   output logic                       vga_h_sync,
   output logic                       vga_v_sync,
   output logic [3:0]                 vga_R,
   output logic [3:0]                 vga_G,
   output logic [3:0]                 vga_B,
   output logic                       frame_start
);

   localparam int          NW       = ROWS*DIGITS*4;
   localparam int          RW       = DIGITS*4;
   localparam int          CELL     = 8 << SCALE;
   localparam logic [11:0] TX0      = 12'(ORIGIN_X);
   localparam logic [11:0] TX1      = 12'(ORIGIN_X + DIGITS*CELL);
   localparam logic [11:0] TY0      = 12'(ORIGIN_Y);
   localparam logic [11:0] TY1      = 12'(ORIGIN_Y + ROWS*CELL);
   localparam logic [11:0] LAST_DIG = 12'(DIGITS - 1);

   function automatic logic [63:0] glyph_of(input logic [3:0] d);
      logic [63:0] g;
      case (d)
         4'h0: g = 64'h7CC6CED6E6C67C00;
         4'h1: g = 64'h30703030303_0FC00;
         4'h2: g = 64'h78CC0C3860C0FC00;
         4'h3: g = 64'h78CC0C380CCC7800;
         4'h4: g = 64'h1C3C6CCCFE0C0C00;
         4'h5: g = 64'hFCC0F80C0CCC7800;
         4'h6: g = 64'h3860C0F8CCCC7800;
         4'h7: g = 64'hFCCC0C1830303000;
         4'h8: g = 64'h78CCCC78CCCC7800;
         4'h9: g = 64'h78CCCC7C0C187000;
         4'hA: g = 64'h3078CCCCFCCCCC00;
         4'hB: g = 64'hFC66667C6666FC00;
         4'hC: g = 64'h3C66C0C0C0663C00;
         4'hD: g = 64'hF86C6666666CF800;
         4'hE: g = 64'hFE6268786862FE00;
         default: g = 64'hFE6268786860F000;
      endcase
      return g;
   endfunction

   logic [9:0]    h_q, v_q, h_d, v_d;
   logic          at_origin;
   logic [NW-1:0] snap_num_q, num_eff;
   logic          snap_img_q, img_eff;

   always_comb begin
      h_d = h_q + 10'd1;
      v_d = v_q;
      if (h_q == 10'd799) begin
         h_d = 10'd0;
         v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
      end
   end

   // The pixel at (0,0) already belongs to the new frame, so it sees the live inputs.
   assign at_origin = (h_q == 10'd0) && (v_q == 10'd0);
   assign num_eff   = at_origin ? numbers : snap_num_q;
   assign img_eff   = at_origin ? image   : snap_img_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q        <= '0;
         v_q        <= '0;
         snap_num_q <= '0;
         snap_img_q <= 1'b0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
         if (at_origin) begin
            snap_num_q <= numbers;
            snap_img_q <= image;
         end
      end
   end

   logic [11:0]   x, y, rx, ry, col, row, didx;
   logic [RW-1:0] row_val;
   logic          act_d, txt_d, blank_d, img1_d, hs1_d, vs1_d, fs1_d;
   logic [2:0]    gx_d, gy_d, bar_d;
   logic [3:0]    nib_d;

   always_comb begin
      x       = {2'b00, h_q};
      y       = {2'b00, v_q};
      rx      = x - TX0;
      ry      = y - TY0;
      col     = rx >> (3 + SCALE);
      row     = ry >> (3 + SCALE);
      didx    = LAST_DIG - col;
      row_val = RW'(num_eff >> (row * RW));
      nib_d   = 4'(row_val >> {didx, 2'b00});
`ifdef VGA_LEADING_ZERO_BLANK_EN
      blank_d = (didx != 12'd0) && ((row_val >> {didx, 2'b00}) == '0);
`else
      blank_d = 1'b0;
`endif
      gx_d    = rx[SCALE+2:SCALE];
      gy_d    = ry[SCALE+2:SCALE];
      act_d   = (h_q < 10'd640) && (v_q < 10'd480);
      txt_d   = (x >= TX0) && (x < TX1) && (y >= TY0) && (y < TY1);
      bar_d   = 3'(h_q / 10'd80);
      img1_d  = img_eff;
      hs1_d   = !((h_q >= 10'd656) && (h_q <= 10'd751));
      vs1_d   = !((v_q >= 10'd490) && (v_q <= 10'd491));
      fs1_d   = at_origin;
   end

   logic        act_q, txt_q, blank_q, img1_q, hs1_q, vs1_q, fs1_q;
   logic [2:0]  gx_q, gy_q, bar_q;
   logic [3:0]  nib_q;
   logic [63:0] glyph;
   logic [7:0]  glyph_row;
   logic        pix_on;
   logic [11:0] rgb_d, rgb_q;
   logic        hs_q, vs_q, fs_q;

   always_comb begin
      glyph     = glyph_of(nib_q);
      glyph_row = 8'(glyph >> {3'd7 - gy_q, 3'b000});
      pix_on    = glyph_row[3'd7 - gx_q];
      rgb_d     = 12'h000;
      if (act_q) begin
         if (img1_q)
            rgb_d = {{4{~bar_q[1]}}, {4{~bar_q[2]}}, {4{~bar_q[0]}}};
         else if (txt_q && !blank_q && pix_on)
            rgb_d = FG;
         else
            rgb_d = BG;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_q   <= 1'b0;
         txt_q   <= 1'b0;
         blank_q <= 1'b0;
         img1_q  <= 1'b0;
         gx_q    <= '0;
         gy_q    <= '0;
         bar_q   <= '0;
         nib_q   <= '0;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         fs1_q   <= 1'b0;
         rgb_q   <= '0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         act_q   <= act_d;
         txt_q   <= txt_d;
         blank_q <= blank_d;
         img1_q  <= img1_d;
         gx_q    <= gx_d;
         gy_q    <= gy_d;
         bar_q   <= bar_d;
         nib_q   <= nib_d;
         hs1_q   <= hs1_d;
         vs1_q   <= vs1_d;
         fs1_q   <= fs1_d;
         rgb_q   <= rgb_d;
         hs_q    <= hs1_q;
         vs_q    <= vs1_q;
         fs_q    <= fs1_q;
      end
   end

   assign vga_R       = rgb_q[11:8];
   assign vga_G       = rgb_q[7:4];
   assign vga_B       = rgb_q[3:0];
   assign vga_h_sync  = hs_q;
   assign vga_v_sync  = vs_q;
   assign frame_start = fs_q;

endmodule
`default_nettype wire
